// File: rtl/id_pkg.sv
// Shared encodings for the instruction-decode stage: MIPS opcodes, R-type funct
// codes and the ALU operation encoding carried into EX.
package id_pkg;

  localparam int RIDX = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

endpackage

// File: rtl/id_stage_reg_file.sv
// Register file for the ID stage: two asynchronous read ports with
// same-cycle writeback bypass, one synchronous write port, register 0 hard-wired to 0.
module reg_file
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RIDX-1:0] rs_idx,
  input  logic [RIDX-1:0] rt_idx,
  output logic [XLEN-1:0] rs_val,
  output logic [XLEN-1:0] rt_val,
  input  logic            we,
  input  logic [RIDX-1:0] wd_idx,
  input  logic [XLEN-1:0] wd_data
);

  logic [XLEN-1:0] regs [NREG];
  logic            wr_en;

  assign wr_en = we && (wd_idx != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wd_idx] <= wd_data;
    end
  end

  // A write landing this cycle is visible to the reader in the same cycle.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs_idx != '0) rs_val = (wr_en && (wd_idx == rs_idx)) ? wd_data : regs[rs_idx];
    if (rt_idx != '0) rt_val = (wr_en && (wd_idx == rt_idx)) ? wd_data : regs[rt_idx];
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: decodes the MIPS subset, resolves beq/bne, raises
// the load-use stall and registers decoded fields into the ID/EX register.
module id_stage
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instruction_ID,
  input  logic [XLEN-1:0] pc_ID,
  input  logic            wb_we,
  input  logic [RIDX-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            branch,
  output logic            jump,
  output logic            stall,
  output logic [XLEN-1:0] ex_rs_val,
  output logic [XLEN-1:0] ex_rt_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [RIDX-1:0] ex_rs,
  output logic [RIDX-1:0] ex_rt,
  output logic [RIDX-1:0] ex_rd,
  output logic [2:0]      ex_alu_op,
  output logic            ex_alu_src,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic [RIDX-1:0] ex_wdst,
  output logic [XLEN-1:0] ex_pc
);

  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic [RIDX-1:0] rs;
  logic [RIDX-1:0] rt;
  logic [RIDX-1:0] rd;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;

  assign opcode = instruction_ID[31:26];
  assign funct  = instruction_ID[5:0];
  assign rs     = instruction_ID[25:21];
  assign rt     = instruction_ID[20:16];
  assign rd     = instruction_ID[15:11];
  assign imm    = {{(XLEN-16){instruction_ID[15]}}, instruction_ID[15:0]};

  reg_file #(.XLEN(XLEN), .NREG(NREG)) u_reg_file (
    .clk     (clk),
    .reset   (reset),
    .rs_idx  (rs),
    .rt_idx  (rt),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .we      (wb_we),
    .wd_idx  (wb_rd),
    .wd_data (wb_data)
  );

  alu_op_e         d_alu_op;
  logic            d_alu_src;
  logic            d_mem_read;
  logic            d_mem_write;
  logic            d_reg_write;
  logic [RIDX-1:0] d_wdst;
  logic            d_reads_rt;
  logic            d_beq;
  logic            d_bne;
  logic            d_j;
  logic            rtype_ok;

  // Unrecognised opcodes and functs fall through with every control bit low (NOP).
  always_comb begin
    d_alu_op    = ALU_ADD;
    d_alu_src   = 1'b0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_reg_write = 1'b0;
    d_wdst      = '0;
    d_reads_rt  = 1'b0;
    d_beq       = 1'b0;
    d_bne       = 1'b0;
    d_j         = 1'b0;
    rtype_ok    = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  d_alu_op = ALU_ADD;
          FN_SUB:  d_alu_op = ALU_SUB;
          FN_AND:  d_alu_op = ALU_AND;
          FN_OR:   d_alu_op = ALU_OR;
          FN_SLT:  d_alu_op = ALU_SLT;
          default: rtype_ok = 1'b0;
        endcase
        if (rtype_ok) begin
          d_reg_write = 1'b1;
          d_wdst      = rd;
          d_reads_rt  = 1'b1;
        end
      end
      OP_ADDI: begin
        d_alu_src   = 1'b1;
        d_reg_write = 1'b1;
        d_wdst      = rt;
      end
      OP_LW: begin
        d_alu_src   = 1'b1;
        d_mem_read  = 1'b1;
        d_reg_write = 1'b1;
        d_wdst      = rt;
      end
      OP_SW: begin
        d_alu_src   = 1'b1;
        d_mem_write = 1'b1;
        d_reads_rt  = 1'b1;
      end
      OP_BEQ: begin
        d_beq      = 1'b1;
        d_reads_rt = 1'b1;
      end
      OP_BNE: begin
        d_bne      = 1'b1;
        d_reads_rt = 1'b1;
      end
      OP_J:    d_j = 1'b1;
      default: ;
    endcase
  end

  // Handshake with fetch: stall=1 means the instruction on instruction_ID is not
  // consumed this cycle (fetch and IF/ID hold it, ID/EX takes a bubble, branch
  // and jump are suppressed); stall=0 means it is consumed at the next clk edge.
  logic operands_eq;

  assign operands_eq = (rs_val == rt_val);
  assign stall  = !reset && ex_mem_read && (ex_wdst != '0) &&
                  ((ex_wdst == rs) || (d_reads_rt && (ex_wdst == rt)));
  assign branch = !reset && !stall && ((d_beq && operands_eq) || (d_bne && !operands_eq));
  assign jump   = !reset && !stall && d_j;

  always_ff @(posedge clk) begin
    if (reset || stall) begin
      ex_rs_val    <= '0;
      ex_rt_val    <= '0;
      ex_imm       <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
      ex_alu_op    <= '0;
      ex_alu_src   <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_wdst      <= '0;
      ex_pc        <= '0;
    end else begin
      ex_rs_val    <= rs_val;
      ex_rt_val    <= rt_val;
      ex_imm       <= imm;
      ex_rs        <= rs;
      ex_rt        <= rt;
      ex_rd        <= rd;
      ex_alu_op    <= d_alu_op;
      ex_alu_src   <= d_alu_src;
      ex_mem_read  <= d_mem_read;
      ex_mem_write <= d_mem_write;
      ex_reg_write <= d_reg_write;
      ex_wdst      <= d_wdst;
      ex_pc        <= pc_ID;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: the driver issues one instruction per cycle and
// queues the expected same-cycle flags and next-cycle ID/EX contents.
module tb_id_stage;
  import id_pkg::*;

  localparam int EXW = 155;

  logic        clk;
  logic        reset;
  logic [31:0] instruction_ID;
  logic [31:0] pc_ID;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        branch;
  logic        jump;
  logic        stall;
  logic [31:0] ex_rs_val;
  logic [31:0] ex_rt_val;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_alu_op;
  logic        ex_alu_src;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic [4:0]  ex_wdst;
  logic [31:0] ex_pc;

  id_stage dut (
    .clk            (clk),
    .reset          (reset),
    .instruction_ID (instruction_ID),
    .pc_ID          (pc_ID),
    .wb_we          (wb_we),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .branch         (branch),
    .jump           (jump),
    .stall          (stall),
    .ex_rs_val      (ex_rs_val),
    .ex_rt_val      (ex_rt_val),
    .ex_imm         (ex_imm),
    .ex_rs          (ex_rs),
    .ex_rt          (ex_rt),
    .ex_rd          (ex_rd),
    .ex_alu_op      (ex_alu_op),
    .ex_alu_src     (ex_alu_src),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_reg_write   (ex_reg_write),
    .ex_wdst        (ex_wdst),
    .ex_pc          (ex_pc)
  );

  // ---------------- clock / reset ----------------
  int cyc;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    int             due;
    bit             is_ex;
    string          name;
    logic [EXW-1:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;

  function automatic logic [EXW-1:0] exv(
    input logic [31:0] rs_val, input logic [31:0] rt_val,
    input logic [31:0] imm, input logic [31:0] pc,
    input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
    input logic [4:0] wdst, input logic [2:0] alu, input logic src,
    input logic mr, input logic mw, input logic rw);
    return {rs_val, rt_val, imm, pc, rs, rt, rd, wdst, alu, src, mr, mw, rw};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Monitor: at each falling edge compare every expectation due this cycle.
  always @(negedge clk) begin
    logic [EXW-1:0] act;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.is_ex)
        act = {ex_rs_val, ex_rt_val, ex_imm, ex_pc, ex_rs, ex_rt, ex_rd, ex_wdst,
               ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write};
      else
        act = {{(EXW-3){1'b0}}, branch, jump, stall};
      n_cmp++;
      if (act !== e.exp || e.due != cyc) begin
        n_bad++;
        $display("FAIL %s%s (cycle %0d, due %0d): got %h expected %h",
                 e.name, e.is_ex ? ".ex" : ".br_j_st", cyc, e.due, act, e.exp);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic [31:0] ins, input logic [31:0] pc,
                      input logic we, input logic [4:0] rd, input logic [31:0] data,
                      input string name, input logic [2:0] cexp,
                      input logic [EXW-1:0] xexp, input bit chk);
    exp_t e;
    @(posedge clk);
    #1;
    reset          = rst;
    instruction_ID = ins;
    pc_ID          = pc;
    wb_we          = we;
    wb_rd          = rd;
    wb_data        = data;
    if (chk) begin
      e.due = cyc;     e.is_ex = 1'b0; e.name = name; e.exp = {{(EXW-3){1'b0}}, cexp};
      exp_q.push_back(e);
      e.due = cyc + 1; e.is_ex = 1'b1; e.name = name; e.exp = xexp;
      exp_q.push_back(e);
    end
  endtask

  logic [31:0] i_add_s2_t1, i_addi_t1, i_add_z, i_bne, i_beq, i_lw, i_add_s1;
  logic [31:0] i_addi_s1, i_j, i_add_s0, i_addi_rs;
  logic [EXW-1:0] zero_ex, lw_ex;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    instruction_ID = '0;
    pc_ID = '0;
    wb_we = 1'b0;
    wb_rd = '0;
    wb_data = '0;

    i_add_s2_t1 = rtype(5'd18, 5'd9, 5'd18, FN_ADD);
    i_addi_t1   = itype(OP_ADDI, 5'd16, 5'd9, 16'hFFFC);
    i_add_z     = rtype(5'd0, 5'd0, 5'd18, FN_ADD);
    i_bne       = itype(OP_BNE, 5'd9, 5'd16, 16'h0003);
    i_beq       = itype(OP_BEQ, 5'd9, 5'd16, 16'hFFFE);
    i_lw        = itype(OP_LW, 5'd9, 5'd17, 16'h0000);
    i_add_s1    = rtype(5'd18, 5'd17, 5'd18, FN_ADD);
    i_addi_s1   = itype(OP_ADDI, 5'd0, 5'd17, 16'h0005);
    i_j         = {OP_J, 26'd2};
    i_add_s0    = rtype(5'd16, 5'd9, 5'd18, FN_ADD);
    i_addi_rs   = itype(OP_ADDI, 5'd17, 5'd8, 16'h0001);
    zero_ex     = '0;

    step(1, 0, 0, 0, 0, 0, "reset0", 3'b000, zero_ex, 0);
    step(1, 0, 0, 0, 0, 0, "reset1", 3'b000, zero_ex, 0);
    step(0, 0, 0, 0, 0, 0, "nop_after_reset", 3'b000, zero_ex, 1);
    step(0, i_add_s2_t1, 32'd4, 1, 5'd9, 32'd400, "add_wb_bypass", 3'b000,
         exv(0, 400, 32'hFFFF9020, 4, 18, 9, 18, 18, ALU_ADD, 0, 0, 0, 1), 1);
    step(0, i_addi_t1, 32'd8, 0, 0, 0, "addi_neg_imm", 3'b000,
         exv(0, 400, 32'hFFFFFFFC, 8, 16, 9, 31, 9, ALU_ADD, 1, 0, 0, 1), 1);
    step(0, i_add_z, 32'd12, 1, 5'd0, 32'd5, "r0_no_bypass", 3'b000,
         exv(0, 0, 32'hFFFF9020, 12, 0, 0, 18, 18, ALU_ADD, 0, 0, 0, 1), 1);
    step(0, i_add_z, 32'd16, 0, 0, 0, "r0_no_write", 3'b000,
         exv(0, 0, 32'hFFFF9020, 16, 0, 0, 18, 18, ALU_ADD, 0, 0, 0, 1), 1);
    step(0, i_bne, 32'd20, 1, 5'd9, 32'd396, "bne_taken", 3'b100,
         exv(396, 0, 3, 20, 9, 16, 0, 0, ALU_ADD, 0, 0, 0, 0), 1);
    step(0, i_bne, 32'd24, 1, 5'd9, 32'd0, "bne_not_taken", 3'b000,
         exv(0, 0, 3, 24, 9, 16, 0, 0, ALU_ADD, 0, 0, 0, 0), 1);
    step(0, i_beq, 32'd28, 0, 0, 0, "beq_taken", 3'b100,
         exv(0, 0, 32'hFFFFFFFE, 28, 9, 16, 31, 0, ALU_ADD, 0, 0, 0, 0), 1);
    step(0, i_beq, 32'd32, 1, 5'd16, 32'd7, "beq_not_taken", 3'b000,
         exv(0, 7, 32'hFFFFFFFE, 32, 9, 16, 31, 0, ALU_ADD, 0, 0, 0, 0), 1);
    lw_ex = exv(0, 0, 0, 36, 9, 17, 0, 17, ALU_ADD, 1, 1, 0, 1);
    step(0, i_lw, 32'd36, 0, 0, 0, "lw", 3'b000, lw_ex, 1);
    step(0, i_add_s1, 32'd40, 0, 0, 0, "load_use_stall_rt", 3'b001, zero_ex, 1);
    step(0, i_add_s1, 32'd40, 0, 0, 0, "after_stall", 3'b000,
         exv(0, 0, 32'hFFFF9020, 40, 18, 17, 18, 18, ALU_ADD, 0, 0, 0, 1), 1);
    step(0, i_lw, 32'd44, 0, 0, 0, "lw2", 3'b000,
         exv(0, 0, 0, 44, 9, 17, 0, 17, ALU_ADD, 1, 1, 0, 1), 1);
    step(0, i_addi_s1, 32'd48, 0, 0, 0, "addi_rt_no_stall", 3'b000,
         exv(0, 0, 5, 48, 0, 17, 0, 17, ALU_ADD, 1, 0, 0, 1), 1);
    step(0, i_j, 32'd52, 0, 0, 0, "jump", 3'b010,
         exv(0, 0, 2, 52, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0), 1);
    step(0, i_lw, 32'd56, 0, 0, 0, "lw3", 3'b000,
         exv(0, 0, 0, 56, 9, 17, 0, 17, ALU_ADD, 1, 1, 0, 1), 1);
    step(1, i_add_s1, 32'd60, 0, 0, 0, "reset_over_stall", 3'b000, zero_ex, 1);
    step(0, i_add_s0, 32'd64, 0, 0, 0, "regs_cleared", 3'b000,
         exv(0, 0, 32'hFFFF9020, 64, 16, 9, 18, 18, ALU_ADD, 0, 0, 0, 1), 1);
    step(0, i_lw, 32'd68, 0, 0, 0, "lw4", 3'b000,
         exv(0, 0, 0, 68, 9, 17, 0, 17, ALU_ADD, 1, 1, 0, 1), 1);
    step(0, i_addi_rs, 32'd72, 0, 0, 0, "load_use_stall_rs", 3'b001, zero_ex, 1);
    step(0, i_addi_rs, 32'd72, 0, 0, 0, "after_stall_rs", 3'b000,
         exv(0, 0, 1, 72, 17, 8, 0, 8, ALU_ADD, 1, 0, 0, 1), 1);
    step(0, 0, 0, 0, 0, 0, "nop_tail", 3'b000, zero_ex, 1);

    // Bounded drain of outstanding expectations.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
